adder_4bit: RTL and testbench

Ripple-carry binary adder: two WIDTH-bit operands plus a carry-in produce a WIDTH-bit sum and a carry-out. The combinational result is available in the same cycle, and a registered copy with a valid flag is captured on the clock. It sits in the datapath wherever a small unsigned or two's-complement add is needed, directly or behind one pipeline stage.

---
 rtl/adder_4bit_pkg.sv | 6 +
 rtl/adder_4bit_full_adder.sv | 16 +
 rtl/adder_4bit.sv | 70 +++++++
 tb/tb_adder_4bit.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/adder_4bit_pkg.sv
// Common datapath constants shared by the adder and its neighbours.
package adder_4bit_pkg;

    localparam int unsigned ADDER_W = 4;

endpackage

// File: rtl/adder_4bit_full_adder.sv
// One-bit full-adder cell; the adder's carry chain is built from WIDTH of these.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign s    = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule

// File: rtl/adder_4bit.sv
// Ripple-carry adder with a same-cycle sum and a one-stage registered copy
// carrying carry-out, two's-complement overflow and a valid flag.
module adder_4bit
    import adder_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q,
    output logic             ovf_q,
    output logic             out_valid
);

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_s;
    logic             w_ovf;

    logic [WIDTH-1:0] r_s_q;
    logic             r_cout_q;
    logic             r_ovf_q;
    logic             r_out_valid;

    assign w_c[0] = cin;

    // Carry ripples strictly bit by bit from cell 0 upward.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        full_adder u_fa (
            .a    (a[gi]),
            .b    (b[gi]),
            .cin  (w_c[gi]),
            .s    (w_s[gi]),
            .cout (w_c[gi+1])
        );
    end

    assign w_ovf = w_c[WIDTH] ^ w_c[WIDTH-1];
    assign s     = w_s;
    assign cout  = w_c[WIDTH];

    // Result register: data holds when idle, valid is a one-cycle pulse per capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_q       <= WIDTH'(0);
            r_cout_q    <= 1'b0;
            r_ovf_q     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_s_q    <= w_s;
                r_cout_q <= w_c[WIDTH];
                r_ovf_q  <= w_ovf;
            end
        end
    end

    assign s_q       = r_s_q;
    assign cout_q    = r_cout_q;
    assign ovf_q     = r_ovf_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: directed vector table, exhaustive sweep, reset corner cases.
module tb_adder_4bit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] s;
    logic         cout;
    logic [W-1:0] s_q;
    logic         cout_q;
    logic         ovf_q;
    logic         out_valid;

    always #5 clk = ~clk;

    adder_4bit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .s         (s),
        .cout      (cout),
        .s_q       (s_q),
        .cout_q    (cout_q),
        .ovf_q     (ovf_q),
        .out_valid (out_valid)
    );

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        exp_t         e;
    } vec_t;

    exp_t sb_q[$];
    exp_t last_e;
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: integer add, overflow from operand/result sign bits.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        exp_t r;
        int   sum;
        logic [31:0] sv;
        sum  = int'(ma) + int'(mb) + int'(mc);
        sv   = 32'(sum);
        r.s    = sv[W-1:0];
        r.cout = sv[W];
        r.ovf  = (ma[W-1] == mb[W-1]) && (r.s[W-1] != ma[W-1]);
        return r;
    endfunction

    // One cycle: drive at negedge, check comb path, check register stage after posedge.
    task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic vv, input exp_t e);
        exp_t got;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = vv;
        #1;
        check("s", 32'(s), 32'(e.s));
        check("cout", 32'(cout), 32'(e.cout));
        if (vv) sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            got = sb_q.pop_front();
            check("out_valid_hi", 32'(out_valid), 32'(1));
            check("s_q", 32'(s_q), 32'(got.s));
            check("cout_q", 32'(cout_q), 32'(got.cout));
            check("ovf_q", 32'(ovf_q), 32'(got.ovf));
            last_e = got;
        end else begin
            check("out_valid_lo", 32'(out_valid), 32'(0));
            check("s_q_hold", 32'(s_q), 32'(last_e.s));
            check("cout_q_hold", 32'(cout_q), 32'(last_e.cout));
            check("ovf_q_hold", 32'(ovf_q), 32'(last_e.ovf));
        end
    endtask

    initial begin
        vec_t tbl[8];
        tbl[0] = '{a: 4'h0, b: 4'h1, cin: 1'b0, e: '{s: 4'h1, cout: 1'b0, ovf: 1'b0}};
        tbl[1] = '{a: 4'h5, b: 4'h5, cin: 1'b1, e: '{s: 4'hB, cout: 1'b0, ovf: 1'b1}};
        tbl[2] = '{a: 4'hF, b: 4'h1, cin: 1'b0, e: '{s: 4'h0, cout: 1'b1, ovf: 1'b0}};
        tbl[3] = '{a: 4'hF, b: 4'hF, cin: 1'b1, e: '{s: 4'hF, cout: 1'b1, ovf: 1'b0}};
        tbl[4] = '{a: 4'h7, b: 4'h1, cin: 1'b0, e: '{s: 4'h8, cout: 1'b0, ovf: 1'b1}};
        tbl[5] = '{a: 4'h8, b: 4'h8, cin: 1'b0, e: '{s: 4'h0, cout: 1'b1, ovf: 1'b1}};
        tbl[6] = '{a: 4'h8, b: 4'hF, cin: 1'b0, e: '{s: 4'h7, cout: 1'b1, ovf: 1'b1}};
        tbl[7] = '{a: 4'h3, b: 4'h4, cin: 1'b0, e: '{s: 4'h7, cout: 1'b0, ovf: 1'b0}};
        last_e = '0;

        // Reset state
        #2;
        check("rst_s_q", 32'(s_q), 32'(0));
        check("rst_cout_q", 32'(cout_q), 32'(0));
        check("rst_ovf_q", 32'(ovf_q), 32'(0));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, back-to-back valid
        for (int i = 0; i < 8; i++) step(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b1, tbl[i].e);

        // Idle cycles: registered result must hold, comb path keeps following inputs
        step(4'h9, 4'h2, 1'b1, 1'b0, '{s: 4'hC, cout: 1'b0, ovf: 1'b0});
        step(4'hA, 4'hA, 1'b0, 1'b0, '{s: 4'h4, cout: 1'b1, ovf: 1'b1});

        // Exhaustive sweep, alternating valid to mix captures and holds
        for (int k = 0; k < 512; k++) begin
            logic [8:0] kv;
            kv = 9'(k);
            step(kv[8:5], kv[4:1], kv[0], logic'((k % 3) != 2), model(kv[8:5], kv[4:1], kv[0]));
        end

        // Three valid cycles, then async reset mid-cycle with a result pending
        step(4'h1, 4'h2, 1'b0, 1'b1, model(4'h1, 4'h2, 1'b0));
        step(4'h6, 4'h3, 1'b1, 1'b1, model(4'h6, 4'h3, 1'b1));
        @(negedge clk);
        a = 4'h7; b = 4'h7; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        check("pre_rst_out_valid", 32'(out_valid), 32'(1));
        check("pre_rst_s_q", 32'(s_q), 32'(4'hE));
        check("pre_rst_ovf_q", 32'(ovf_q), 32'(1));
        #1;
        rst_n = 1'b0;
        #1;
        check("async_s_q", 32'(s_q), 32'(0));
        check("async_cout_q", 32'(cout_q), 32'(0));
        check("async_ovf_q", 32'(ovf_q), 32'(0));
        check("async_out_valid", 32'(out_valid), 32'(0));
        check("rst_comb_s", 32'(s), 32'(4'hE));
        check("rst_comb_cout", 32'(cout), 32'(0));
        // Valid input during reset is never captured
        @(posedge clk);
        #1;
        check("in_rst_out_valid", 32'(out_valid), 32'(0));
        check("in_rst_s_q", 32'(s_q), 32'(0));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        sb_q.delete();
        last_e = '0;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", 32'(out_valid), 32'(0));
        check("post_rst_s_q", 32'(s_q), 32'(0));
        step(4'h2, 4'h2, 1'b0, 1'b0, model(4'h2, 4'h2, 1'b0));
        // First capture after release
        step(4'hC, 4'h5, 1'b1, 1'b1, model(4'hC, 4'h5, 1'b1));
        step(4'h0, 4'h0, 1'b0, 1'b0, model(4'h0, 4'h0, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
